// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and default widths/denominations for the vending controller
package vend_pkg;
  localparam int DEF_AMT_W = 9;
  localparam int DEF_CNT_W = 8;
  localparam logic [3*DEF_AMT_W-1:0] DEF_COIN_VAL = {9'd5, 9'd10, 9'd25};
  typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, REFUND} state_e;
endpackage

// File: rtl/vend_inv_bank.sv
// vend_inv_bank: per-denomination saturating coin counters with registered empty flags
module vend_inv_bank
  import vend_pkg::*;
#(
  parameter int NUM_COINS = 3,
  parameter int CNT_W = DEF_CNT_W,
  parameter int INIT_CNT = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_COINS-1:0]                inc,
  input  logic [NUM_COINS-1:0]                dec,
  input  logic                                refill_go,
  input  logic [$clog2(NUM_COINS)-1:0]        refill_sel,
  input  logic [CNT_W-1:0]                    refill_qty,
  output logic [NUM_COINS-1:0][CNT_W-1:0]     cnt,
  output logic [NUM_COINS-1:0]                empty
);
  localparam int SEL_W = $clog2(NUM_COINS);
  logic [NUM_COINS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_COINS-1:0][CNT_W:0] sum;
  logic [NUM_COINS-1:0] empty_q, empty_d;
  always_comb begin
    sum = '0;
    cnt_d = cnt_q;
    empty_d = empty_q;
    for (int i = 0; i < NUM_COINS; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + {1'b0, refill_qty};
      cnt_d[i] = dec[i] ? cnt_q[i] - CNT_W'(1) :
                 inc[i] ? (&cnt_q[i] ? cnt_q[i] : cnt_q[i] + CNT_W'(1)) :
                 (refill_go && refill_sel == SEL_W'(i)) ? (sum[i][CNT_W] ? '1 : sum[i][CNT_W-1:0]) :
                 cnt_q[i];
      empty_d[i] = cnt_d[i] == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {NUM_COINS{CNT_W'(INIT_CNT)}};
      empty_q <= {NUM_COINS{INIT_CNT == 0}};
    end else begin
      cnt_q <= cnt_d;
      empty_q <= empty_d;
    end
  end
  assign cnt = cnt_q;
  assign empty = empty_q;
endmodule

// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl: vending controller that proves greedy change is payable before committing a sale
module vend_change_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_COINS = 3,
  parameter int AMT_W = DEF_AMT_W,
  parameter logic [NUM_COINS*AMT_W-1:0] COIN_VAL = DEF_COIN_VAL,
  parameter int CNT_W = DEF_CNT_W,
  parameter int INIT_CNT = 10,
  parameter int MAX_CREDIT = 2**AMT_W-1,
  parameter int TOT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_COINS-1:0]         coin_det,
  input  logic                         buy,
  input  logic [AMT_W-1:0]             price,
  input  logic                         return_coins,
  input  logic                         refill_en,
  input  logic [$clog2(NUM_COINS)-1:0] refill_sel,
  input  logic [CNT_W-1:0]             refill_qty,
  output logic                         ok,
  output logic                         buy_rej,
  output logic                         coin_rej,
  output logic                         refund_err,
  output logic                         refill_ack,
  output logic [NUM_COINS-1:0]         ret_coin,
  output logic [AMT_W-1:0]             amount,
  output logic [TOT_W-1:0]             total,
  output logic [NUM_COINS-1:0]         empty,
  output logic                         busy
);
  localparam int IDX_W = $clog2(NUM_COINS+1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COINS-1);
  state_e state_q, state_d;
  logic [AMT_W-1:0] amount_q, amount_d, rem_q, rem_d, price_q, price_d;
  logic [AMT_W-1:0] cur_val, coin_val_in, walk_rem;
  logic [TOT_W-1:0] total_q, total_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_COINS-1:0][CNT_W-1:0] cnt, sim_q, sim_d;
  logic [CNT_W-1:0] cur_cnt, cur_sim, walk_cnt;
  logic [NUM_COINS-1:0] idx_oh, inc, ret_q, ret_d;
  logic ok_q, ok_d, buy_rej_q, buy_rej_d, coin_rej_q, coin_rej_d;
  logic refund_err_q, refund_err_d, refill_ack_q, refill_ack_d, busy_q;
  logic coin_any, coin_full, coin_ok, refill_go, take;
  vend_inv_bank #(.NUM_COINS(NUM_COINS), .CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_bank (
    .clk(clk), .rst(rst), .inc(inc), .dec(ret_d), .refill_go(refill_go),
    .refill_sel(refill_sel), .refill_qty(refill_qty), .cnt(cnt), .empty(empty)
  );
  always_comb begin
    cur_val = '0;
    cur_cnt = '0;
    cur_sim = '0;
    idx_oh = '0;
    coin_val_in = '0;
    coin_full = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_val = COIN_VAL[i*AMT_W +: AMT_W];
        cur_cnt = cnt[i];
        cur_sim = sim_q[i];
        idx_oh[i] = 1'b1;
      end
      if (coin_det[i]) begin
        coin_val_in = COIN_VAL[i*AMT_W +: AMT_W];
        coin_full = &cnt[i];
      end
    end
  end
  assign coin_any = |coin_det;
  assign coin_ok = $onehot(coin_det) && !coin_full &&
                   ({1'b0, amount_q} + {1'b0, coin_val_in}) <= (AMT_W+1)'(MAX_CREDIT);
  assign walk_rem = state_q == CHECK ? rem_q : amount_q;
  assign walk_cnt = state_q == CHECK ? cur_sim : cur_cnt;
  assign take = walk_rem >= cur_val && walk_cnt != '0;
  always_comb begin
    state_d = state_q;
    amount_d = amount_q;
    total_d = total_q;
    rem_d = rem_q;
    price_d = price_q;
    idx_d = idx_q;
    sim_d = sim_q;
    ok_d = 1'b0;
    buy_rej_d = 1'b0;
    coin_rej_d = coin_any && state_q != IDLE;
    refund_err_d = 1'b0;
    refill_ack_d = 1'b0;
    ret_d = '0;
    inc = '0;
    refill_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (return_coins) begin
          coin_rej_d = coin_any;
          idx_d = '0;
          state_d = REFUND;
        end else if (buy) begin
          coin_rej_d = coin_any;
          if (price == '0 || price > amount_q) begin
            buy_rej_d = 1'b1;
          end else begin
            rem_d = amount_q - price;
            price_d = price;
            sim_d = cnt;
            idx_d = '0;
            state_d = CHECK;
          end
        end else if (coin_any) begin
          coin_rej_d = !coin_ok;
          inc = coin_ok ? coin_det : '0;
          amount_d = coin_ok ? amount_q + coin_val_in : amount_q;
        end else if (refill_en && int'(refill_sel) < NUM_COINS) begin
          refill_go = 1'b1;
          refill_ack_d = 1'b1;
        end
      end
      CHECK: begin
        if (rem_q == '0) begin
          ok_d = 1'b1;
          amount_d = amount_q - price_q;
          total_d = total_q + TOT_W'(price_q);
          idx_d = '0;
          state_d = DISPENSE;
        end else if (take) begin
          rem_d = rem_q - cur_val;
          for (int i = 0; i < NUM_COINS; i++) sim_d[i] = sim_q[i] - CNT_W'(idx_oh[i]);
        end else if (idx_q == LAST) begin
          buy_rej_d = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        if (amount_q == '0) begin
          state_d = IDLE;
        end else if (take) begin
          ret_d = idx_oh;
          amount_d = amount_q - cur_val;
        end else if (idx_q == LAST) begin
          refund_err_d = state_q == REFUND;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      amount_q <= '0;
      total_q <= '0;
      rem_q <= '0;
      price_q <= '0;
      idx_q <= '0;
      sim_q <= '0;
      ok_q <= 1'b0;
      buy_rej_q <= 1'b0;
      coin_rej_q <= 1'b0;
      refund_err_q <= 1'b0;
      refill_ack_q <= 1'b0;
      ret_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      amount_q <= amount_d;
      total_q <= total_d;
      rem_q <= rem_d;
      price_q <= price_d;
      idx_q <= idx_d;
      sim_q <= sim_d;
      ok_q <= ok_d;
      buy_rej_q <= buy_rej_d;
      coin_rej_q <= coin_rej_d;
      refund_err_q <= refund_err_d;
      refill_ack_q <= refill_ack_d;
      ret_q <= ret_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign ok = ok_q;
  assign buy_rej = buy_rej_q;
  assign coin_rej = coin_rej_q;
  assign refund_err = refund_err_q;
  assign refill_ack = refill_ack_q;
  assign ret_coin = ret_q;
  assign amount = amount_q;
  assign total = total_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_vend_change_ctrl.sv
// tb_vend_change_ctrl: table-driven vectors plus directed multi-cycle sequences for vend_change_ctrl
module tb_vend_change_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] coin_det = '0;
  logic buy = 1'b0, return_coins = 1'b0, refill_en = 1'b0;
  logic [8:0] price = '0;
  logic [1:0] refill_sel = '0;
  logic [7:0] refill_qty = '0;
  logic ok, buy_rej, coin_rej, refund_err, refill_ack, busy;
  logic [2:0] ret_coin, empty;
  logic [8:0] amount;
  logic [15:0] total;
  logic [2:0] b_coin = '0;
  logic b_buy = 1'b0, b_ret = 1'b0, b_ren = 1'b0;
  logic [8:0] b_price = '0;
  logic [1:0] b_rsel = '0;
  logic [7:0] b_rqty = '0;
  logic b_ok, b_buy_rej, b_coin_rej, b_refund_err, b_refill_ack, b_busy;
  logic [2:0] b_ret_coin, b_empty;
  logic [8:0] b_amount;
  logic [15:0] b_total;
  int n_total = 0, n_bad = 0, a_err_cnt = 0;
  always #5 clk = ~clk;
  vend_change_ctrl dut (
    .clk(clk), .rst(rst), .coin_det(coin_det), .buy(buy), .price(price),
    .return_coins(return_coins), .refill_en(refill_en), .refill_sel(refill_sel),
    .refill_qty(refill_qty), .ok(ok), .buy_rej(buy_rej), .coin_rej(coin_rej),
    .refund_err(refund_err), .refill_ack(refill_ack), .ret_coin(ret_coin),
    .amount(amount), .total(total), .empty(empty), .busy(busy)
  );
  vend_change_ctrl #(.INIT_CNT(0)) dut_b (
    .clk(clk), .rst(rst), .coin_det(b_coin), .buy(b_buy), .price(b_price),
    .return_coins(b_ret), .refill_en(b_ren), .refill_sel(b_rsel),
    .refill_qty(b_rqty), .ok(b_ok), .buy_rej(b_buy_rej), .coin_rej(b_coin_rej),
    .refund_err(b_refund_err), .refill_ack(b_refill_ack), .ret_coin(b_ret_coin),
    .amount(b_amount), .total(b_total), .empty(b_empty), .busy(b_busy)
  );
  always @(negedge clk) if (!rst && refund_err) a_err_cnt++;
  typedef struct packed {
    logic [2:0] coin;
    logic       buy;
    logic [8:0] price;
    logic       ret;
    logic       ren;
    logic [1:0] rsel;
    logic [7:0] rqty;
    logic [3:0] e_pul;
    logic [2:0] e_ret;
    logic [8:0] e_amt;
    logic       e_busy;
  } vec_t;
  vec_t tbl [32];
  function automatic vec_t v(input logic [2:0] c, input logic b, input int p, input logic r,
                             input logic re, input int rs, input int rq, input logic [3:0] pul,
                             input logic [2:0] rc, input int amt, input logic bz);
    vec_t t;
    t.coin = c;
    t.buy = b;
    t.price = 9'(p);
    t.ret = r;
    t.ren = re;
    t.rsel = 2'(rs);
    t.rqty = 8'(rq);
    t.e_pul = pul;
    t.e_ret = rc;
    t.e_amt = 9'(amt);
    t.e_busy = bz;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] c, input logic b, input int p, input logic r);
    @(negedge clk);
    coin_det = c;
    buy = b;
    price = 9'(p);
    return_coins = r;
    refill_en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic bstep(input logic [2:0] c, input logic b, input int p, input logic r);
    @(negedge clk);
    b_coin = c;
    b_buy = b;
    b_price = 9'(p);
    b_ret = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n25, n5, nb;
    logic seen_ok, seen_rej;
    tbl[0]  = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 0,  0);
    tbl[1]  = v(1, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 25, 0);
    tbl[2]  = v(2, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 35, 0);
    tbl[3]  = v(4, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 40, 0);
    tbl[4]  = v(0, 1, 25, 0, 0, 0, 0, 4'b0000, 3'b000, 40, 1);
    tbl[5]  = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 40, 1);
    tbl[6]  = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 40, 1);
    tbl[7]  = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 40, 1);
    tbl[8]  = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 40, 1);
    tbl[9]  = v(0, 0, 0,  0, 0, 0, 0, 4'b1000, 3'b000, 15, 1);
    tbl[10] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 15, 1);
    tbl[11] = v(4, 0, 0,  0, 0, 0, 0, 4'b0010, 3'b010, 5,  1);
    tbl[12] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 5,  1);
    tbl[13] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b100, 0,  1);
    tbl[14] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 0,  0);
    tbl[15] = v(2, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 10, 0);
    tbl[16] = v(2, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 20, 0);
    tbl[17] = v(1, 1, 20, 0, 0, 0, 0, 4'b0010, 3'b000, 20, 1);
    tbl[18] = v(0, 0, 0,  0, 0, 0, 0, 4'b1000, 3'b000, 0,  1);
    tbl[19] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 0,  0);
    tbl[20] = v(4, 0, 0,  0, 1, 0, 5, 4'b0000, 3'b000, 5,  0);
    tbl[21] = v(0, 0, 0,  0, 1, 2, 3, 4'b0001, 3'b000, 5,  0);
    tbl[22] = v(0, 1, 10, 0, 0, 0, 0, 4'b0100, 3'b000, 5,  0);
    tbl[23] = v(0, 1, 0,  0, 0, 0, 0, 4'b0100, 3'b000, 5,  0);
    tbl[24] = v(3, 0, 0,  0, 0, 0, 0, 4'b0010, 3'b000, 5,  0);
    tbl[25] = v(0, 0, 0,  1, 0, 0, 0, 4'b0000, 3'b000, 5,  1);
    tbl[26] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 5,  1);
    tbl[27] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 5,  1);
    tbl[28] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b100, 0,  1);
    tbl[29] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 0,  0);
    tbl[30] = v(0, 0, 0,  1, 0, 0, 0, 4'b0000, 3'b000, 0,  1);
    tbl[31] = v(0, 0, 0,  0, 0, 0, 0, 4'b0000, 3'b000, 0,  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_amount", 32'(amount), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_pulses", 32'({ok, buy_rej, coin_rej, refund_err, refill_ack}), 0);
    chk("rst_ret_busy", 32'({ret_coin, busy}), 0);
    chk("rst_empty", 32'(empty), 0);
    chk("rst_b_empty", 32'(b_empty), 32'h7);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      coin_det = tbl[i].coin;
      buy = tbl[i].buy;
      price = tbl[i].price;
      return_coins = tbl[i].ret;
      refill_en = tbl[i].ren;
      refill_sel = tbl[i].rsel;
      refill_qty = tbl[i].rqty;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", i), 32'({ok, buy_rej, coin_rej, refill_ack, ret_coin, amount, busy}),
          32'({tbl[i].e_pul, tbl[i].e_ret, tbl[i].e_amt, tbl[i].e_busy}));
    end
    chk("total_after_table", 32'(total), 45);
    for (int i = 0; i < 20; i++) step(3'b001, 0, 0, 0);
    step(3'b100, 0, 0, 0);
    chk("ceiling_fill", 32'(amount), 505);
    step(3'b010, 0, 0, 0);
    chk("ceiling_rej", 32'({coin_rej, amount}), 32'({1'b1, 9'd505}));
    step(0, 0, 0, 1);
    n25 = 0;
    n5 = 0;
    for (int k = 0; k < 60; k++) begin
      step(0, 0, 0, 0);
      if (ret_coin == 3'b001) n25++;
      if (ret_coin == 3'b100) n5++;
      if (!busy) break;
    end
    chk("refund505_n25", 32'(n25), 20);
    chk("refund505_n5", 32'(n5), 1);
    chk("refund505_done", 32'({busy, amount}), 0);
    chk("no_refund_err", 32'(a_err_cnt), 0);
    step(3'b001, 0, 0, 0);
    step(0, 1, 5, 0);
    seen_ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0);
      if (ok) begin
        seen_ok = 1'b1;
        break;
      end
    end
    chk("mid_ok_seen", 32'(seen_ok), 1);
    chk("mid_total", 32'(total), 50);
    step(0, 0, 0, 0);
    chk("mid_dispensing", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'({busy, ret_coin, ok, amount}), 0);
    chk("mid_rst_total", 32'(total), 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);
    chk("post_rst_quiet", 32'({busy, ret_coin, ok, amount}), 0);
    bstep(3'b001, 0, 0, 0);
    chk("b_amount25", 32'(b_amount), 25);
    bstep(0, 0, 0, 0);
    chk("b_empty_after_coin", 32'(b_empty), 32'h6);
    bstep(0, 1, 20, 0);
    seen_ok = 1'b0;
    seen_rej = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bstep(0, 0, 0, 0);
      if (b_ok) seen_ok = 1'b1;
      if (b_buy_rej) begin
        seen_rej = 1'b1;
        break;
      end
    end
    chk("b_buy_rej", 32'({seen_rej, seen_ok}), 32'b10);
    chk("b_credit_kept", 32'(b_amount), 25);
    bstep(0, 0, 0, 1);
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      bstep(0, 0, 0, 0);
      if (b_ret_coin != 3'b000) nb += (b_ret_coin == 3'b001) ? 1 : 100;
      if (!b_busy) break;
    end
    chk("b_refund_coins", 32'(nb), 1);
    chk("b_refund_done", 32'({b_busy, b_amount, b_total}), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/vend_change_ctrl.md
# vend_change_ctrl

Parametrised vending controller with per-denomination coin inventory and exact-change verification. Accepts coins from N detectors, accumulates credit, and on `buy` proves that greedy change is payable from stock before committing the sale. It then dispenses change one coin per cycle. It sits behind the coin acceptor and ahead of the hopper drivers, replacing the fixed 5/10/25 controller.

## Interface
- `NUM_COINS`, 3: number of denominations.
- `AMT_W`, 9: credit, price and denomination width.
- `COIN_VAL`, {25,10,5}: denomination values, index 0 largest, strictly descending.
- `CNT_W`, 8: inventory counter width.
- `INIT_CNT`, 10: inventory count of every denomination after reset.
- `MAX_CREDIT`, 2**AMT_W-1: credit ceiling.
- `TOT_W`, 16: sales total width, wraps.

Ports:
- `clk`  in  1  clock, single domain
- `rst`  in  1  synchronous, active-high reset
- `coin_det`  in  NUM_COINS  one-cycle coin-detect pulse per denomination
- `buy`  in  1  purchase request pulse
- `price`  in  AMT_W  item price, sampled on `buy`
- `return_coins`  in  1  refund request pulse
- `refill_en`  in  1  add stock
- `refill_sel`  in  $clog2(NUM_COINS)  denomination to refill
- `refill_qty`  in  CNT_W  coins added
- `ok`  out  1  vend pulse
- `buy_rej`  out  1  buy refused (short credit, price 0, or change not payable)
- `coin_rej`  out  1  inserted coin diverted to the reject chute
- `refund_err`  out  1  refund ended with residual credit
- `refill_ack`  out  1  refill applied
- `ret_coin`  out  NUM_COINS  one-hot, one coin dispensed this cycle
- `amount`  out  AMT_W  current credit
- `total`  out  TOT_W  accumulated sales
- `empty`  out  NUM_COINS  inventory count == 0
- `busy`  out  1  state != IDLE

## Operation
- States are IDLE, CHECK, DISPENSE and REFUND.
- **IDLE event priority:** `return_coins` > `buy` > coin > refill.
- **Coin insertion** (IDLE, single-hot `coin_det[i]`):
  - Accept if `amount+COIN_VAL[i] <= MAX_CREDIT` and `cnt[i]` is not saturated: `amount += COIN_VAL[i]` and `cnt[i]++`.
  - Otherwise, and for any multi-hot `coin_det`, pulse `coin_rej`; credit and counts are unchanged.
- **Coin during busy, or coin in the same cycle as `buy`/`return_coins`:** pulse `coin_rej`.
- **buy:**
  - If `price==0` or `price > amount`, pulse `buy_rej` and stay in IDLE.
  - Otherwise latch `rem = amount - price`, copy counts to `sim_cnt`, set `idx = 0`, and go to CHECK.
- **CHECK**, one step per cycle:
  - If `rem==0`: success. Pulse `ok`, `amount <= amount - price_q`, `total += price_q`, go to DISPENSE with `idx = 0`.
  - Else if `rem >= COIN_VAL[idx]` and `sim_cnt[idx] > 0`: `rem -= COIN_VAL[idx]`, `sim_cnt[idx]--`.
  - Else `idx++`. If `idx` passes `NUM_COINS-1` with `rem != 0`: pulse `buy_rej`, return to IDLE, credit unchanged.
- **DISPENSE:** replays the same greedy walk on the real counts with `amount` as the remainder.
  - Each cycle either emits one `ret_coin[idx]` (with `cnt[idx]--` and `amount -= COIN_VAL[idx]`) or advances `idx`.
  - When `amount==0`, go to IDLE.
- **REFUND** (`return_coins` in IDLE): the same greedy walk on `amount`.
  - If `idx` is exhausted with `amount != 0`: pulse `refund_err`, keep the residual credit, go to IDLE.
  - With `amount==0` at entry, go straight back to IDLE with no pulses.
- **Refill:** applied only in IDLE when no coin, `buy` or `return_coins` is present. `cnt[sel]` saturates at `2**CNT_W-1`; pulse `refill_ack`. Otherwise the refill is dropped and the source retries.

## Timing
- All outputs are registered.
- Values after reset:
  - 0: `amount`, `total`, all pulses, `busy`.
  - Counts: `INIT_CNT`.
  - `empty`: `INIT_CNT==0`.
  - State: IDLE.
- Coin accepted at edge t: `amount` updates at t+1.
- Buy at t: CHECK begins t+1. `ok`/`buy_rej` is asserted exactly one cycle, in the cycle after the deciding CHECK step.
- CHECK latency is at most `NUM_COINS + number of coins taken` cycles.
- `ret_coin` is at most one-hot and at most one coin per cycle.
- `empty` updates the cycle after its count changes.
- `rst` mid-operation: next cycle IDLE, all reset values, and no further pulses.

## Structure
- Package `vend_pkg` holds:
  - the state enum;
  - the default `COIN_VAL` array;
  - the `AMT_W`/`CNT_W` defaults.
- Sub-module `vend_inv_bank` contains:
  - the per-denomination saturating counters (inc on coin, dec on dispense, add on refill);
  - the `empty` flags.
- The FSM, credit register and greedy walker stay in the top module.

## Test plan
- **Reset:** all outputs 0, `empty=000`, `amount=0`.
- **Vend with change:** insert 25, 10, 5 (`amount=40`), buy price 25. Expect one `ok`, then `ret_coin[1]` followed by `ret_coin[2]`; `amount=0`, `total=25`.
- **Unpayable change:** `INIT_CNT=0`, insert 25, buy price 20. Expect `buy_rej`, `amount=25`. Then `return_coins` gives one `ret_coin[0]` and `amount=0`.
- **Credit ceiling:** `amount=505`, insert 10. Expect `coin_rej`, `amount=505`.
- **Collisions:** `coin_det` in the same cycle as `buy` gives `coin_rej` and the buy proceeds. A coin during DISPENSE gives `coin_rej`. Refill together with a coin gives no `refill_ack`.
- **Reset mid-DISPENSE:** assert `rst` mid-DISPENSE. Next cycle IDLE, `ret_coin=0`, `amount=0`, `total=0`.
